// File: rtl/data_sram_bridge.sv
// data_sram_bridge: memory-stage SRAM port to split address/data handshake bus with pipeline stall
// Define WRITE_BUFFER_EN for a one-entry posted store buffer; TIMEOUT_CYCLES=0 disables the abort timer.
module data_sram_bridge #(
  parameter int TIMEOUT_CYCLES = 0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        mem_en,
  input  logic [3:0]  mem_wen,
  input  logic [31:0] mem_addr,
  input  logic [31:0] mem_wdata,
  output logic [31:0] mem_rdata,
  output logic        stall,
  output logic        bus_error,
  output logic        bus_req,
  output logic        bus_wr,
  output logic [1:0]  bus_size,
  output logic [31:0] bus_addr,
  output logic [31:0] bus_wdata,
  input  logic        bus_addr_ok,
  input  logic        bus_data_ok,
  input  logic [31:0] bus_rdata
);
`ifdef WRITE_BUFFER_EN
  localparam bit WB = 1'b1;
`else
  localparam bit WB = 1'b0;
`endif
  localparam logic [31:0] TO = 32'(TIMEOUT_CYCLES);
  typedef enum logic [1:0] {IDLE, REQ, WAIT, DONE} state_t;
  state_t state, state_n;
  logic [31:0] cnt, rdata_q;
  logic posted, err_q, is_st, post, busy, fin, abort;
  logic [1:0] size_d;
  always_comb begin
    is_st = |mem_wen;
    size_d = (mem_wen inside {4'b0001, 4'b0010, 4'b0100, 4'b1000}) ? 2'd0 :
             (mem_wen inside {4'b0011, 4'b1100}) ? 2'd1 : 2'd2;
    post = WB && is_st;
    busy = state == REQ || state == WAIT;
    fin = (state == REQ && bus_addr_ok && bus_data_ok) || (state == WAIT && bus_data_ok);
    abort = busy && !fin && TO != 32'd0 && cnt + 32'd1 == TO;
    // a posted store finishes in the background, so it skips the DONE release cycle
    state_n = state == IDLE ? (mem_en ? REQ : IDLE) :
              state == DONE ? IDLE :
              (fin || abort) ? (posted ? IDLE : DONE) :
              (state == REQ && bus_addr_ok) ? WAIT : state;
    stall = state == IDLE ? mem_en && !post : busy && (!posted || mem_en);
  end
  always_ff @(posedge clk) begin
    if (!rst) begin
      state <= IDLE;
      cnt <= '0;
      rdata_q <= '0;
      err_q <= 1'b0;
      posted <= 1'b0;
    end else begin
      state <= state_n;
      cnt <= busy ? cnt + 32'd1 : '0;
      err_q <= abort;
      if (fin && !bus_wr) rdata_q <= bus_rdata;
      else if (abort && !posted) rdata_q <= '0;
      if (state == IDLE && mem_en) posted <= post;
    end
  end
  always_ff @(posedge clk) begin
    if (state == IDLE && mem_en) begin
      bus_wr <= is_st;
      bus_size <= size_d;
      bus_addr <= is_st ? mem_addr : {mem_addr[31:2], 2'b00};
      bus_wdata <= mem_wdata;
    end
  end
  assign bus_req = state == REQ;
  assign mem_rdata = rdata_q;
  assign bus_error = err_q;
endmodule
